operand_fetch: RTL



---
 rtl/operand_fetch.sv | 94 +++++++++
 1 files changed

// File: rtl/operand_fetch.sv
`default_nettype none
// operand_fetch: register-read stage that bypasses same-cycle writeback, tracks
// in-flight destinations in a scoreboard, stalls on hazards and registers operands.
module operand_fetch #(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_opcode,
  input  logic [2:0]             in_rs,
  input  logic [2:0]             in_rt,
  input  logic                   in_use_rt,
  input  logic [WIDTH-1:0]       in_imm,
  input  logic [2:0]             in_rd,
  input  logic                   in_wr,
  input  logic [NREGS*WIDTH-1:0] rf_q,
  input  logic [NREGS-1:0]       wb_en,
  input  logic [WIDTH-1:0]       wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_opcode,
  output logic [2:0]             out_rd,
  output logic                   out_wr,
  output logic [WIDTH-1:0]       out_a,
  output logic [WIDTH-1:0]       out_b
);

  logic [WIDTH-1:0] regs_w [NREGS];
  logic [NREGS-1:0] pending_q, pending_d;
  logic             out_valid_q;
  logic [3:0]       out_opcode_q;
  logic [2:0]       out_rd_q;
  logic             out_wr_q;
  logic [WIDTH-1:0] out_a_q, out_b_q;
  logic [WIDTH-1:0] rs_val_w, rt_val_w;
  logic             hazard_w, accept_w;

  for (genvar i = 0; i < NREGS; i++) begin : g_unpack
    assign regs_w[i] = rf_q[WIDTH*i +: WIDTH];
  end

  // The bank only shows a write one cycle later, so forward it ourselves.
  assign rs_val_w = wb_en[in_rs] ? wb_data : regs_w[in_rs];
  assign rt_val_w = wb_en[in_rt] ? wb_data : regs_w[in_rt];

  assign hazard_w = (pending_q[in_rs] & ~wb_en[in_rs])
                  | (in_use_rt & pending_q[in_rt] & ~wb_en[in_rt])
                  | (in_wr & pending_q[in_rd] & ~wb_en[in_rd]);

  assign in_ready = ~hazard_w & (~out_valid_q | out_ready);
  assign accept_w = in_valid & in_ready;

  always_comb begin
    pending_d = pending_q & ~wb_en;
    // A new claim on rd outranks a writeback retiring the older one.
    if (accept_w && in_wr) pending_d[in_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      out_valid_q  <= 1'b0;
      out_opcode_q <= '0;
      out_rd_q     <= '0;
      out_wr_q     <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
    end else begin
      pending_q <= pending_d;
      if (accept_w) begin
        out_valid_q  <= 1'b1;
        out_opcode_q <= in_opcode;
        out_rd_q     <= in_rd;
        out_wr_q     <= in_wr;
        out_a_q      <= rs_val_w;
        out_b_q      <= in_use_rt ? rt_val_w : in_imm;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_opcode = out_opcode_q;
  assign out_rd     = out_rd_q;
  assign out_wr     = out_wr_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;

endmodule
`default_nettype wire
